// File: rtl/maxpool_pkg.sv
// Shared state encoding, default frame dimensions and counter sizing for the
// 2x2 max-pool stream controller.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_IMAGE_WIDTH  = 8;
    localparam int DEF_IMAGE_HEIGHT = 8;
    localparam int DEF_DATA_W       = 8;

    // Counter width for a position range of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_pos_cnt.sv
// Column/row position tracker for one frame: raster wrap, the odd/odd flag
// marking the pixel that completes a 2x2 block, and the last-pixel flag.
module maxpool_pos_cnt
    import maxpool_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic pool_pixel,
    output logic last_pixel
);

    localparam int COL_W = cnt_width(IMAGE_WIDTH);
    localparam int ROW_W = cnt_width(IMAGE_HEIGHT);

    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic             col_last, row_last;

    assign col_last = (col_reg == COL_W'(IMAGE_WIDTH - 1));
    assign row_last = (row_reg == ROW_W'(IMAGE_HEIGHT - 1));

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (clear) begin
            col_next = '0;
            row_next = '0;
        end else if (advance) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + ROW_W'(1);
            end else begin
                col_next = col_reg + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Bottom-right pixel of each 2x2 block sits at odd column and odd row.
    assign pool_pixel = col_reg[0] & row_reg[0];
    assign last_pixel = col_last & row_last;

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Stream controller for an external 2x2 max-pool datapath: paces pixel input,
// captures each pooled result and hands it downstream with valid/ready.
// Optional abort input enabled by defining MAXPOOL_CTRL_ABORT_EN.
module maxpool_stream_ctrl
    import maxpool_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef MAXPOOL_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_en,
    input  logic [DATA_W-1:0] pool_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_reg, state_next;
    logic              pending_reg, pending_next;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              abort_hit;
    logic              cnt_clear;
    logic              pool_pixel;
    logic              last_pixel;

`ifdef MAXPOOL_CTRL_ABORT_EN
    assign abort_hit = abort & ((state_reg == RUN) | (state_reg == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    assign cnt_clear = (state_reg == IDLE) | abort_hit;

    maxpool_pos_cnt #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_pos_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .advance    (shift_en),
        .pool_pixel (pool_pixel),
        .last_pixel (last_pixel)
    );

    always_comb begin
        state_next   = state_reg;
        in_ready     = 1'b0;
        shift_en     = 1'b0;
        pending_next = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // Stall input while an unconsumed result is stuck downstream.
                in_ready     = ~(out_valid_reg & ~out_ready) & ~abort_hit;
                shift_en     = in_valid & in_ready;
                pending_next = shift_en & pool_pixel;
                if (abort_hit)                    state_next = IDLE;
                else if (shift_en && last_pixel)  state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort_hit)                          state_next = IDLE;
                else if (!pending_reg && !out_valid_reg) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            // Capture wins over consume so back-to-back results never drop.
            if (abort_hit) begin
                out_valid_reg <= 1'b0;
            end else if (pending_reg) begin
                out_data_reg  <= pool_in;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Scoreboard bench for maxpool_stream_ctrl: random frames, an emulated pooling
// datapath, and a monitor checking pooled outputs, latency and frame framing.
module tb_maxpool_stream_ctrl;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int DW   = 8;
    localparam int NOUT = (W / 2) * (H / 2);

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] pool_in   = '0;
    logic          in_ready, shift_en, out_valid, busy, done;
    logic [DW-1:0] out_data;
`ifdef MAXPOOL_CTRL_ABORT_EN
    logic          abort     = 1'b0;
`endif

    always #5 clk = ~clk;

    maxpool_stream_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .DATA_W       (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef MAXPOOL_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .pool_in   (pool_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Frame image and its expected 2x2 maxima (written only between frames).
    logic [DW-1:0] img [W*H];
    logic [DW-1:0] blk [NOUT];
    logic [DW-1:0] exp_q [$];

    // Monitor-owned state.
    int            checks = 0, failures = 0, cycle = 0;
    int            hs_count = 0, out_count = 0, first_hs_cyc = 0;
    int            lat_cyc_q [$];
    logic [DW-1:0] lat_val_q [$];
    bit            first_ov_seen = 0, frame_active = 0, frame_done = 0;
    bit            hold_prev = 0, done_prev = 0, abort_chk = 0, tmo_seen = 0;
    logic [DW-1:0] data_prev = '0;
    int            pend_cyc = -1;
    logic [DW-1:0] pend_val = '0;

    // Stimulus-owned controls.
    int iv_mode  = 0;   // 0: always valid, 1: random valid
    int or_mode  = 0;   // 0: always ready, 1: random, 2: stall 5 cycles at first valid
    bit lat11_en = 0;
    bit tmo_req  = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Input driver plus emulated datapath: the pooled maximum appears on
    // pool_in in the cycle after the block-completing handshake, noise otherwise.
    int bp_cnt = 0;
    always @(posedge clk) begin
        #1;
        in_valid = (iv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (or_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else if (or_mode == 2 && out_valid && bp_cnt < 5) begin
            out_ready = 1'b0;
            bp_cnt++;
        end else begin
            out_ready = 1'b1;
        end
        if (or_mode != 2) bp_cnt = 0;
        pool_in = (pend_cyc == cycle) ? pend_val : DW'($urandom);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        int c, r;
        logic [DW-1:0] v;
        if (reset) begin
            chk({out_valid, in_ready, shift_en, busy, done, out_data} == '0, "reset_outputs",
                {out_valid, in_ready, shift_en, busy, done, out_data}, 0);
            exp_q.delete(); lat_cyc_q.delete(); lat_val_q.delete();
            frame_active = 0; hs_count = 0; hold_prev = 0; done_prev = 0; abort_chk = 0;
        end else begin
            if (start && !busy && !done) begin
                frame_active = 1; frame_done = 0; hs_count = 0; out_count = 0; first_ov_seen = 0;
            end
            if (abort_chk) begin
                chk(!busy && !out_valid && !done, "abort_to_idle", {busy, out_valid, done}, 0);
                abort_chk = 0;
            end
            if (lat_cyc_q.size() > 0 && lat_cyc_q[0] == cycle) begin
                chk(out_valid && out_data == lat_val_q[0], "capture_latency",
                    {out_valid, out_data}, {1'b1, lat_val_q[0]});
                void'(lat_cyc_q.pop_front());
                void'(lat_val_q.pop_front());
            end
            if (hold_prev)
                chk(out_valid && out_data == data_prev, "hold_stable", {out_valid, out_data}, {1'b1, data_prev});
            if (out_valid && !out_ready)
                chk(!in_ready, "backpressure_in_ready", in_ready, 0);
            if (!busy)
                chk(!in_ready, "idle_in_ready", in_ready, 0);
            if (in_valid)
                chk(shift_en == in_ready, "shift_en", shift_en, in_ready);
            if (out_valid && out_ready) begin
                chk(exp_q.size() > 0, "output_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    $display("out %0d data=%02h expected=%02h", out_count, out_data, exp_q[0]);
                    chk(out_data == exp_q[0], "out_data", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                out_count++;
            end
            if (out_valid && frame_active && !first_ov_seen) begin
                first_ov_seen = 1;
                if (lat11_en)
                    chk(cycle - first_hs_cyc == 11, "first_out_latency", cycle - first_hs_cyc, 11);
            end
            if (done) begin
                chk(frame_active && !done_prev, "done_pulse", {frame_active, done_prev}, 2);
                chk(out_count == NOUT, "frame_outputs", out_count, NOUT);
                chk(hs_count == W * H, "frame_pixels", hs_count, W * H);
                frame_active = 0;
                frame_done   = 1;
            end
            if (shift_en) begin
                if (hs_count == 0) first_hs_cyc = cycle;
                c = hs_count % W;
                r = hs_count / W;
                if (c % 2 == 1 && r % 2 == 1) begin
                    v = blk[(r / 2) * (W / 2) + c / 2];
                    lat_cyc_q.push_back(cycle + 2);
                    lat_val_q.push_back(v);
                    pend_cyc = cycle + 1;
                    pend_val = v;
                end
                hs_count++;
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
            done_prev = done;
`ifdef MAXPOOL_CTRL_ABORT_EN
            if (abort && busy) begin
                exp_q.delete(); lat_cyc_q.delete(); lat_val_q.delete();
                frame_active = 0; hold_prev = 0; abort_chk = 1;
            end
`endif
        end
        if (tmo_req && !tmo_seen) begin
            tmo_seen = 1;
            chk(1'b0, "wait_timeout", 0, 1);
        end
        cycle++;
    end

    // Fill a frame and queue its pooled outputs in raster order.
    task automatic gen_frame(input bit force_3c);
        logic [DW-1:0] m;
        for (int i = 0; i < W * H; i++) img[i] = DW'($urandom);
        if (force_3c) begin
            img[0]     = 8'h3C;
            img[1]     = DW'($urandom_range(0, 8'h3C));
            img[W]     = DW'($urandom_range(0, 8'h3C));
            img[W + 1] = DW'($urandom_range(0, 8'h3C));
        end
        for (int br = 0; br < H / 2; br++) begin
            for (int bc = 0; bc < W / 2; bc++) begin
                m = 0;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (img[(2 * br + dy) * W + 2 * bc + dx] > m) m = img[(2 * br + dy) * W + 2 * bc + dx];
                blk[br * (W / 2) + bc] = m;
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        for (int t = 0; t < 2000 && hs_count < n; t++) begin
            @(posedge clk); #1;
        end
        if (hs_count < n) tmo_req = 1;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 3000 && !frame_done; t++) begin
            @(posedge clk); #1;
        end
        if (!frame_done) tmo_req = 1;
    endtask

    task automatic run_frame(input bit force_3c);
        gen_frame(force_3c);
        pulse_start();
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Continuous flow: first result 11 cycles after first handshake.
        lat11_en = 1; run_frame(0); lat11_en = 0;
        // Downstream stall at first result.
        or_mode = 2; run_frame(0); or_mode = 0;
        // Known pooled value in the first block.
        run_frame(1);
        // Reset mid-frame, then a clean frame.
        gen_frame(0); pulse_start(); wait_hs(20);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_frame(0);
        // Start while running is ignored.
        gen_frame(0); pulse_start(); wait_hs(10); pulse_start(); wait_done();
        // Random flow control on both sides.
        iv_mode = 1; or_mode = 1;
        repeat (3) run_frame(0);
`ifdef MAXPOOL_CTRL_ABORT_EN
        iv_mode = 0;
        gen_frame(0); pulse_start(); wait_hs(30);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        iv_mode = 1;
        run_frame(0);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxpool_stream_ctrl.md
MAXPOOL_STREAM_CTRL -- requirements
Module: maxpool_stream_ctrl

Interface
REQ-001 Parameter IMAGE_WIDTH, default 8, pixels per row; SHALL be even and at least 2.
REQ-002 Parameter IMAGE_HEIGHT, default 8, rows per frame; SHALL be even and at least 2.
REQ-003 Parameter DATA_W, default 8, pixel width in bits.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  one-cycle frame start request; honoured only in IDLE.
REQ-007 Port in_valid  input  1  upstream pixel valid.
REQ-008 Port in_ready  output  1  controller accepts pixel; handshake = in_valid & in_ready.
REQ-009 Port shift_en  output  1  datapath shift enable, equal to the handshake (combinational).
REQ-010 Port pool_in  input  DATA_W  2x2 max result from the pooling datapath.
REQ-011 Port out_data  output  DATA_W  registered pooled pixel.
REQ-012 Port out_valid  output  1  out_data valid; held until out_ready.
REQ-013 Port out_ready  input  1  downstream accepts out_data.
REQ-014 Port busy  output  1  high in RUN and DRAIN.
REQ-015 Port done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: in_ready=0; start -> RUN; col, row and pending cleared.
REQ-018 RUN: in_ready = ~(out_valid & ~out_ready).
REQ-019 Each handshake: col increments; col==IMAGE_WIDTH-1 wraps to 0 and increments row.
REQ-020 Handshake with col odd and row odd: set pending for exactly the next cycle.
REQ-021 While pending: capture pool_in into out_data and set out_valid at that edge.
REQ-022 Latency: handshake in cycle k -> out_valid high in cycle k+2.
REQ-023 out_valid clears on out_valid & out_ready unless a capture occurs at the same edge.
REQ-024 If capture and consume coincide, new data loads and out_valid stays 1.
REQ-025 Handshake at row==IMAGE_HEIGHT-1, col==IMAGE_WIDTH-1: RUN -> DRAIN; in_ready=0 from then.
REQ-026 DRAIN -> DONE once pending==0 and out_valid==0.
REQ-027 DONE: done=1 for one cycle, then IDLE.
REQ-028 start outside IDLE is ignored.
REQ-029 Each frame produces exactly (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2) outputs, in raster order.
REQ-030 Counters are sized clog2 of their parameter; they do not wrap inside a frame.

Reset
REQ-031 Reset asserted: state=IDLE; col, row, pending=0; out_data=0; out_valid, done, in_ready, shift_en, busy=0.
REQ-032 Reset mid-frame discards the frame; no done pulse.

Configuration
REQ-033 Macro MAXPOOL_CTRL_ABORT_EN defined: input port abort, 1 bit.
REQ-034 abort in RUN or DRAIN: next edge -> IDLE, counters and pending cleared, out_valid=0, no done; abort has priority over the handshake in that cycle.
REQ-035 Macro undefined: no abort port; behaviour as REQ-016..REQ-030.

Structure
REQ-036 Package maxpool_pkg SHALL hold the state enum (IDLE, RUN, DRAIN, DONE) and the default-dimension constants.
REQ-037 Sub-module maxpool_pos_cnt SHALL own col/row counting, wrap and the last-pixel flag.
REQ-038 The pooling datapath is instantiated outside this block; this block contains no comparators.

Verification
REQ-039 Test 1 (8x8, out_ready=1, in_valid=1 throughout): start -> 64 handshakes, 16 outputs; first output in cycle 11 after the first handshake; done 1 pulse.
REQ-040 Test 2 (backpressure): out_ready=0 for 5 cycles at the first out_valid -> in_ready=0 and out_data stable; release -> all 16 outputs with no loss or duplication.
REQ-041 Test 3 (pool_in=0x3C during pending): out_data=0x3C two cycles after the handshake at row1/col1.
REQ-042 Test 4: reset pulse after 20 pixels -> all outputs 0; then start -> full clean frame of 16 outputs.
REQ-043 Test 5: start during RUN -> ignored; output count still 16.
REQ-044 Test 6 (MAXPOOL_CTRL_ABORT_EN): abort after 30 pixels -> IDLE next cycle, out_valid=0, no done.
